// File: rtl/coin_acceptor_if.sv
// Coin acceptor customer/dispenser/washer-side signal bundle.
//   master : drives coin_in_raw, coin_value, cancel, wm_busy, refund_ack; observes the rest.
//   slave  : the coin_acceptor itself.
//   coin_in_raw   raw coin-slot sensor (asynchronous, bouncing)
//   coin_value    coin denomination, stable while coin_in_raw is high
//   cancel        customer refund request (level)
//   wm_busy       washing machine running, inhibits start
//   refund_ack    dispenser accepted refund_amount
//   coin          one-cycle start pulse to the washing machine
//   credit        accumulated credit
//   refund_valid  refund pending, refund_amount stable while high
//   refund_amount value to dispense
//   reject        one-cycle pulse, coin refused
interface coin_acceptor_if #(
  parameter int unsigned CREDIT_W = 8
);
  logic                coin_in_raw;
  logic [3:0]          coin_value;
  logic                cancel;
  logic                wm_busy;
  logic                refund_ack;
  logic                coin;
  logic [CREDIT_W-1:0] credit;
  logic                refund_valid;
  logic [CREDIT_W-1:0] refund_amount;
  logic                reject;

  modport master (
    output coin_in_raw, coin_value, cancel, wm_busy, refund_ack,
    input  coin, credit, refund_valid, refund_amount, reject
  );

  modport slave (
    input  coin_in_raw, coin_value, cancel, wm_busy, refund_ack,
    output coin, credit, refund_valid, refund_amount, reject
  );
endinterface

// File: rtl/coin_acceptor.sv
// Coin acceptor: payment front-end for the washing machine controller.
// Synchronises and debounces the coin-slot sensor, accumulates credit up to MAX_CREDIT,
// issues a one-cycle 'coin' start pulse per PRICE of credit while the machine is idle,
// and runs a cancel/refund handshake with the dispenser.
// Ports:
//   clk  system clock, rising edge
//   rst  asynchronous active-low reset
//   bus  coin_acceptor_if.slave (sensor, denomination, cancel, wm_busy, refund handshake,
//        coin pulse, credit, reject)
// Optional feature: define COIN_TIMEOUT_EN to refund partial credit (0 < credit < PRICE)
// after TIMEOUT_CYCLES consecutive COLLECT cycles without a coin event.
module coin_acceptor #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned PRICE           = 10,
  parameter int unsigned CREDIT_W        = 8,
  parameter int unsigned MAX_CREDIT      = 200,
  parameter int unsigned TIMEOUT_CYCLES  = 1000
) (
  input logic            clk,
  input logic            rst,
  coin_acceptor_if.slave bus
);

  localparam int unsigned DbW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DbW-1:0]      DbLast = DbW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CREDIT_W-1:0] PriceW = CREDIT_W'(PRICE);
  localparam logic [CREDIT_W:0]   MaxW   = (CREDIT_W + 1)'(MAX_CREDIT);

  if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
    $error("DEBOUNCE_CYCLES must be at least 1");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  typedef enum logic [1:0] {StIdle, StCollect, StVend, StRefund} state_e;

  // Input path
  logic           raw_meta_q, raw_sync_q;
  logic [3:0]     val_meta_q, val_sync_q;
  logic           filt_q, filt_prev_q;
  logic [DbW-1:0] db_cnt_q;
  logic           coin_event;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      raw_meta_q  <= 1'b0;
      raw_sync_q  <= 1'b0;
      val_meta_q  <= '0;
      val_sync_q  <= '0;
      filt_q      <= 1'b0;
      filt_prev_q <= 1'b0;
      db_cnt_q    <= '0;
    end else begin
      raw_meta_q  <= bus.coin_in_raw;
      raw_sync_q  <= raw_meta_q;
      val_meta_q  <= bus.coin_value;
      val_sync_q  <= val_meta_q;
      filt_prev_q <= filt_q;
      // Any sample agreeing with the filtered level restarts the run.
      if (raw_sync_q != filt_q) begin
        if (db_cnt_q == DbLast) begin
          filt_q   <= raw_sync_q;
          db_cnt_q <= '0;
        end else begin
          db_cnt_q <= db_cnt_q + 1'b1;
        end
      end else begin
        db_cnt_q <= '0;
      end
    end
  end

  assign coin_event = filt_q & ~filt_prev_q;

  // Control
  state_e              state_q;
  logic [CREDIT_W-1:0] credit_q, refund_amount_q;
  logic                coin_q, reject_q, refund_valid_q;
  logic [CREDIT_W:0]   sum_w;
  logic                accept;
  logic [CREDIT_W-1:0] credit_acc, vend_credit;

`ifdef COIN_TIMEOUT_EN
  localparam int unsigned TmoW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT_CYCLES - 1);
  logic [TmoW-1:0] tmo_cnt_q;
`endif

  // One bit wider than credit so the ceiling compare cannot wrap.
  always_comb begin
    sum_w       = {1'b0, credit_q} + (CREDIT_W + 1)'(val_sync_q);
    accept      = coin_event && (sum_w <= MaxW);
    credit_acc  = accept ? sum_w[CREDIT_W-1:0] : credit_q;
    vend_credit = credit_acc - PriceW;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q         <= StIdle;
      credit_q        <= '0;
      coin_q          <= 1'b0;
      reject_q        <= 1'b0;
      refund_valid_q  <= 1'b0;
      refund_amount_q <= '0;
`ifdef COIN_TIMEOUT_EN
      tmo_cnt_q       <= '0;
`endif
    end else begin
      coin_q   <= 1'b0;
      reject_q <= coin_event && !accept;
`ifdef COIN_TIMEOUT_EN
      tmo_cnt_q <= '0;
`endif
      case (state_q)
        StIdle: begin
          if (accept) begin
            credit_q <= credit_acc;
            state_q  <= StCollect;
          end
        end
        StCollect: begin
          credit_q <= credit_acc;
          if (bus.cancel && credit_q != '0) begin
            state_q         <= StRefund;
            refund_valid_q  <= 1'b1;
            refund_amount_q <= credit_acc;
          end else if (credit_q >= PriceW && !bus.wm_busy) begin
            // Pulse is registered so it is high exactly while in StVend.
            state_q <= StVend;
            coin_q  <= 1'b1;
          end
`ifdef COIN_TIMEOUT_EN
          else if (credit_q != '0 && credit_q < PriceW) begin
            if (coin_event) begin
              tmo_cnt_q <= '0;
            end else if (tmo_cnt_q == TmoLast) begin
              state_q         <= StRefund;
              refund_valid_q  <= 1'b1;
              refund_amount_q <= credit_q;
            end else begin
              tmo_cnt_q <= tmo_cnt_q + 1'b1;
            end
          end
`endif
        end
        StVend: begin
          credit_q <= vend_credit;
          state_q  <= (vend_credit != '0) ? StCollect : StIdle;
        end
        StRefund: begin
          reject_q <= coin_event;
          if (bus.refund_ack) begin
            credit_q        <= '0;
            refund_valid_q  <= 1'b0;
            refund_amount_q <= '0;
            state_q         <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.coin          = coin_q;
  assign bus.credit        = credit_q;
  assign bus.refund_valid  = refund_valid_q;
  assign bus.refund_amount = refund_amount_q;
  assign bus.reject        = reject_q;

endmodule

// File: tb/tb_coin_acceptor.sv
// Bench for coin_acceptor: directed scenarios followed by randomized coin / busy / refund
// steps checked against a transaction-level credit model.
module tb_coin_acceptor;
  localparam int unsigned D      = 4;
  localparam int unsigned PRICE  = 10;
  localparam int unsigned W      = 8;
  localparam int unsigned MAXC   = 200;
  localparam int unsigned TMO    = 1000;
  localparam int unsigned SETTLE = 48;

  logic clk = 1'b0;
  logic rst = 1'b0;

  coin_acceptor_if #(.CREDIT_W(W)) ifc ();

  coin_acceptor #(
    .DEBOUNCE_CYCLES(D),
    .PRICE          (PRICE),
    .CREDIT_W       (W),
    .MAX_CREDIT     (MAXC),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(ifc)
  );

  always #5 clk = ~clk;

  int n_pass = 0, n_fail = 0, n_total = 0;
  int n_coin = 0, n_rej = 0;           // observed pulses
  int m_credit = 0, m_coin = 0, m_rej = 0;  // model
  bit busy = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      if (ifc.coin === 1'b1) n_coin++;
      if (ifc.reject === 1'b1) n_rej++;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Idle machine vends one wash per PRICE of credit.
  function automatic void apply_vend();
    if (!busy) begin
      while (m_credit >= int'(PRICE)) begin
        m_credit -= PRICE;
        m_coin++;
      end
    end
  endfunction

  task automatic insert_coin(input int v);
    ifc.coin_value  = 4'(v);
    ifc.coin_in_raw = 1'b1;
    tick(D + 6);
    ifc.coin_in_raw = 1'b0;
    tick(D + 6);
    ifc.coin_value  = 4'd0;
  endtask

  task automatic coin_step(input int v);
    insert_coin(v);
    tick(SETTLE);
    if (m_credit + v > int'(MAXC)) m_rej++;
    else m_credit += v;
    apply_vend();
  endtask

  task automatic set_busy(input bit b);
    ifc.wm_busy = b;
    busy = b;
    tick(SETTLE);
    apply_vend();
  endtask

  task automatic refund_step(input bit coin_during, input int v);
    ifc.cancel = 1'b1;
    tick(2);
    ifc.cancel = 1'b0;
    if (m_credit > 0) begin
      check("refund_valid", ifc.refund_valid, 1);
      check("refund_amount", ifc.refund_amount, m_credit);
      if (coin_during) begin
        insert_coin(v);
        m_rej++;
        check("refund_credit_hold", ifc.credit, m_credit);
        check("refund_amount_hold", ifc.refund_amount, m_credit);
        check("refund_rejects", n_rej, m_rej);
      end
      ifc.refund_ack = 1'b1;
      tick(1);
      ifc.refund_ack = 1'b0;
      m_credit = 0;
      check("ack_credit", ifc.credit, 0);
      check("ack_valid", ifc.refund_valid, 0);
    end else begin
      check("cancel_ignored", ifc.refund_valid, 0);
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, "_credit"}, ifc.credit, m_credit);
    check({tag, "_coins"}, n_coin, m_coin);
    check({tag, "_rejects"}, n_rej, m_rej);
  endtask

  initial begin
    ifc.coin_in_raw = 1'b0;
    ifc.coin_value  = 4'd0;
    ifc.cancel      = 1'b0;
    ifc.wm_busy     = 1'b0;
    ifc.refund_ack  = 1'b0;

    // Reset held while the sensor toggles.
    for (int i = 0; i < 6; i++) begin
      ifc.coin_in_raw = ~ifc.coin_in_raw;
      ifc.coin_value  = 4'd10;
      tick(1);
      check("rst_coin", ifc.coin, 0);
      check("rst_credit", ifc.credit, 0);
    end
    check("rst_refund_valid", ifc.refund_valid, 0);
    check("rst_refund_amount", ifc.refund_amount, 0);
    check("rst_reject", ifc.reject, 0);
    ifc.coin_in_raw = 1'b0;
    ifc.coin_value  = 4'd0;
    rst = 1'b1;
    tick(D + 8);
    check("post_rst_coins", n_coin, 0);

    // Clean 10-unit coin: latency and vend pulse.
    ifc.coin_value  = 4'd10;
    ifc.coin_in_raw = 1'b1;
    tick(D + 2);
    check("lat_before", ifc.credit, 0);
    tick(1);
    check("lat_credit", ifc.credit, 10);
    tick(1);
    check("vend_pulse", ifc.coin, 1);
    tick(1);
    check("vend_pulse_end", ifc.coin, 0);
    check("vend_credit", ifc.credit, 0);
    ifc.coin_in_raw = 1'b0;
    tick(D + 6);
    ifc.coin_value = 4'd0;
    m_coin = 1;
    check_model("clean");

    // Glitches of 3 cycles are filtered out.
    for (int i = 0; i < 5; i++) begin
      ifc.coin_value  = 4'd7;
      ifc.coin_in_raw = 1'b1;
      tick(3);
      ifc.coin_in_raw = 1'b0;
      tick(2);
    end
    ifc.coin_value = 4'd0;
    tick(10);
    check_model("bounce");

    // Busy machine holds credit, vends once when released.
    set_busy(1'b1);
    repeat (3) coin_step(5);
    check("busy_credit", ifc.credit, 15);
    check_model("busy");
    set_busy(1'b0);
    check("busy_release_credit", ifc.credit, 5);
    check_model("busy_release");

    // Cancel with partial credit, coin during refund rejected.
    coin_step(2);
    check("pre_refund_credit", ifc.credit, 7);
    refund_step(1'b1, 9);
    check_model("refund");

    // Ceiling: 195 + 10 rejected, 195 + 5 lands exactly on MAX_CREDIT.
    set_busy(1'b1);
    repeat (13) coin_step(15);
    check("ceil_195", ifc.credit, 195);
    coin_step(10);
    check("ceil_reject_credit", ifc.credit, 195);
    check_model("ceil_reject");
    coin_step(5);
    check("ceil_exact", ifc.credit, 200);
    coin_step(1);
    check_model("ceil_over");
    refund_step(1'b0, 0);
    set_busy(1'b0);
    check_model("ceil_done");

`ifdef COIN_TIMEOUT_EN
    coin_step(4);
    check("tmo_before", ifc.refund_valid, 0);
    tick(TMO);
    check("tmo_valid", ifc.refund_valid, 1);
    check("tmo_amount", ifc.refund_amount, 4);
    ifc.refund_ack = 1'b1;
    tick(1);
    ifc.refund_ack = 1'b0;
    m_credit = 0;
    check_model("tmo");
`endif

    // Reset while a refund is pending drops it at once.
    coin_step(3);
    ifc.cancel = 1'b1;
    tick(2);
    ifc.cancel = 1'b0;
    check("midrst_pending", ifc.refund_valid, 1);
    rst = 1'b0;
    #1;
    check("midrst_valid", ifc.refund_valid, 0);
    check("midrst_credit", ifc.credit, 0);
    check("midrst_amount", ifc.refund_amount, 0);
    tick(2);
    rst = 1'b1;
    m_credit = 0;
    tick(2);
    check_model("midrst");

    // Randomized coins, busy toggles and refunds.
    for (int i = 0; i < 30; i++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r <= 5) coin_step($urandom_range(0, 15));
      else if (r <= 7) set_busy(~busy);
      else refund_step(1'($urandom_range(0, 1)), $urandom_range(0, 15));
      check_model("rand");
    end
    set_busy(1'b0);
    check_model("final");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
